// File: rtl/step_burst_gen.sv
// Step-pulse burst generator: emits N programmable-width step pulses, one per accepted
// divider tick, with a direction line latched and held stable for the whole burst.
module step_burst_gen #(
    parameter int CNT_W     = 32,
    parameter int PW_W      = 8,
    parameter int SETUP_CYC = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick,
    input  logic             start,
    input  logic             abort,
    input  logic             dir_in,
    input  logic [CNT_W-1:0] steps_in,
    input  logic [PW_W-1:0]  pulse_len,
    output logic             step,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining
);

    localparam int SC_W = (SETUP_CYC < 2) ? 1 : $clog2(SETUP_CYC + 1);
    localparam logic [SC_W-1:0] SETUP_LOAD = SC_W'(SETUP_CYC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_WAIT_TICK,
        S_PULSE,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SC_W-1:0]  r_setup_cnt;
    logic [SC_W-1:0]  w_setup_cnt_nxt;
    logic [PW_W-1:0]  r_plen;
    logic [PW_W-1:0]  w_plen_nxt;
    logic [PW_W-1:0]  r_width_cnt;
    logic [PW_W-1:0]  w_width_cnt_nxt;
    logic [CNT_W-1:0] r_remaining;
    logic [CNT_W-1:0] w_remaining_nxt;
    logic             r_step;
    logic             w_step_nxt;
    logic             r_dir;
    logic             w_dir_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic [PW_W-1:0]  w_plen_eff;

    // A zero width would never let the pulse end, so it is stretched to one cycle.
    assign w_plen_eff = (pulse_len == '0) ? PW_W'(1) : pulse_len;

    // NOTE: counters and latched fields are reset too, so the block leaves reset in a
    // fully known state even if software reads remaining before the first burst.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_setup_cnt <= '0;
            r_plen      <= '0;
            r_width_cnt <= '0;
            r_remaining <= '0;
            r_step      <= 1'b0;
            r_dir       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // NOTE: non-blocking here so every register samples the pre-edge values.
            r_state     <= w_state_nxt;
            r_setup_cnt <= w_setup_cnt_nxt;
            r_plen      <= w_plen_nxt;
            r_width_cnt <= w_width_cnt_nxt;
            r_remaining <= w_remaining_nxt;
            r_step      <= w_step_nxt;
            r_dir       <= w_dir_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    always_comb begin
        // NOTE: every target gets a default first; a missed branch would infer a latch.
        w_state_nxt     = r_state;
        w_setup_cnt_nxt = r_setup_cnt;
        w_plen_nxt      = r_plen;
        w_width_cnt_nxt = r_width_cnt;
        w_remaining_nxt = r_remaining;
        w_step_nxt      = r_step;
        w_dir_nxt       = r_dir;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_dir_nxt = dir_in;
                    if (steps_in != '0) begin
                        w_state_nxt     = S_SETUP;
                        w_setup_cnt_nxt = SETUP_LOAD;
                        w_plen_nxt      = w_plen_eff;
                        w_remaining_nxt = steps_in;
                        w_busy_nxt      = 1'b1;
                    end else begin
                        w_state_nxt     = S_DONE;
                        w_remaining_nxt = '0;
                        w_done_nxt      = 1'b1;
                    end
                end
            end

            S_SETUP: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                end else if (r_setup_cnt == SC_W'(1)) begin
                    w_state_nxt = S_WAIT_TICK;
                end else begin
                    w_setup_cnt_nxt = r_setup_cnt - SC_W'(1);
                end
            end

            S_WAIT_TICK: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                end else if (tick) begin
                    w_state_nxt     = S_PULSE;
                    w_step_nxt      = 1'b1;
                    w_width_cnt_nxt = r_plen;
                end
            end

            S_PULSE: begin
                if (abort) begin
                    // The interrupted pulse is not counted: remaining stays put.
                    w_state_nxt = S_IDLE;
                    w_step_nxt  = 1'b0;
                    w_busy_nxt  = 1'b0;
                end else if (r_width_cnt == PW_W'(1)) begin
                    w_step_nxt = 1'b0;
                    if (r_remaining != '0) begin
                        w_remaining_nxt = r_remaining - CNT_W'(1);
                    end
                    if (r_remaining <= CNT_W'(1)) begin
                        w_state_nxt = S_DONE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT_TICK;
                    end
                end else begin
                    w_width_cnt_nxt = r_width_cnt - PW_W'(1);
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_step_nxt  = 1'b0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign step      = r_step;
    assign dir       = r_dir;
    assign busy      = r_busy;
    assign done      = r_done;
    assign remaining = r_remaining;

    // A step pulse is only ever driven inside a burst, and done is a single-cycle strobe.
    a_step_in_burst : assert property (@(posedge clk) disable iff (!reset_n) r_step |-> r_busy);
    a_done_strobe   : assert property (@(posedge clk) disable iff (!reset_n) r_done |=> !r_done);

endmodule
